// File: rtl/pipeline_sequencer_if.sv
// Command/status bundle between the debug unit (master) and the pipeline
// run/step/halt sequencer (slave). Instruction seen at IF rides along so
// the sequencer can spot HALT at fetch.
interface pipeline_sequencer_if #(
  parameter int LENGTH_INSTRUCTION = 32,
  parameter int CANT_BITS_CICLOS   = 32
);

  // Debug-unit commands, one-cycle pulses
  logic                          i_cmd_run;
  logic                          i_cmd_step;
  logic                          i_cmd_stop;
  logic                          i_cmd_clear;

  // Instruction currently presented by the fetch stage
  logic [LENGTH_INSTRUCTION-1:0] i_instruction_if;

  // Enables and status back to the stages and the debug unit
  logic                          o_enable_pipeline;
  logic                          o_enable_etapa;
  logic                          o_enable_fetch;
  logic                          o_halted;
  logic                          o_step_done;
  logic [CANT_BITS_CICLOS-1:0]   o_cycle_count;
  logic [2:0]                    o_state;

  modport master (
    output i_cmd_run, i_cmd_step, i_cmd_stop, i_cmd_clear, i_instruction_if,
    input  o_enable_pipeline, o_enable_etapa, o_enable_fetch, o_halted,
           o_step_done, o_cycle_count, o_state
  );

  modport slave (
    input  i_cmd_run, i_cmd_step, i_cmd_stop, i_cmd_clear, i_instruction_if,
    output o_enable_pipeline, o_enable_etapa, o_enable_fetch, o_halted,
           o_step_done, o_cycle_count, o_state
  );

endinterface

// File: rtl/pipeline_sequencer.sv
// Run/step/halt controller for the MIPS pipeline. Produces the per-cycle
// enables for every stage, stops fetching when HALT reaches IF, lets the
// in-flight instructions drain for a fixed number of cycles and then parks
// the pipeline. Also counts enabled cycles for the debug report.
// Enables are Moore-decoded straight from the state register so an
// asynchronous reset drops them in the same cycle.
module pipeline_sequencer #(
  parameter int              LENGTH_INSTRUCTION = 32,
  parameter int              CANT_BITS_OPCODE   = 6,
  parameter logic [5:0]      HALT_OPCODE        = 6'b111111,
  parameter int              CANT_CICLOS_DRAIN  = 4,
  parameter int              CANT_BITS_CICLOS   = 32
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  pipeline_sequencer_if.slave  bus
);

  // Drain length is limited to 1..15, so 4 bits always suffice
  localparam int DRAIN_W = 4;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(CANT_CICLOS_DRAIN);
  localparam logic [CANT_BITS_CICLOS-1:0] COUNT_MAX = {CANT_BITS_CICLOS{1'b1}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t                      state_reg;
  state_t                      state_next;
  logic [DRAIN_W-1:0]          drain_count_reg;
  logic [DRAIN_W-1:0]          drain_count_next;
  logic [CANT_BITS_CICLOS-1:0] cycle_count_reg;
  logic                        step_done_reg;

  logic                        count_clear;
  logic                        stages_active;
  logic                        halt_hit;
  logic [CANT_BITS_OPCODE-1:0] opcode_if;

  assign opcode_if = bus.i_instruction_if[LENGTH_INSTRUCTION-1 -: CANT_BITS_OPCODE];

  // HALT only matters while fetch is actually enabled
  assign halt_hit = ((state_reg == RUN) || (state_reg == STEP)) &&
                    (opcode_if == HALT_OPCODE[CANT_BITS_OPCODE-1:0]);

  assign stages_active = (state_reg == RUN) || (state_reg == STEP) ||
                         (state_reg == DRAIN);

  // State and drain counter registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_reg       <= IDLE;
      drain_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      drain_count_reg <= drain_count_next;
    end
  end

  // Next-state logic: command decode, halt detection and drain countdown
  always_comb begin
    state_next       = state_reg;
    drain_count_next = drain_count_reg;
    count_clear      = 1'b0;
    case (state_reg)
      IDLE: begin
        count_clear = bus.i_cmd_clear;
        // stop outranks run, run outranks step; stop alone is a no-op here
        if (bus.i_cmd_stop) begin
          state_next = IDLE;
        end else if (bus.i_cmd_run) begin
          state_next = RUN;
        end else if (bus.i_cmd_step) begin
          state_next = STEP;
        end
      end
      RUN: begin
        // A fetched HALT wins over a simultaneous stop
        if (halt_hit) begin
          state_next       = DRAIN;
          drain_count_next = DRAIN_LOAD;
        end else if (bus.i_cmd_stop) begin
          state_next = IDLE;
        end
      end
      STEP: begin
        if (halt_hit) begin
          state_next       = DRAIN;
          drain_count_next = DRAIN_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      DRAIN: begin
        // Commands are ignored so the drain always completes. A zero count
        // can only come from a corrupted register; park rather than wrap.
        drain_count_next = drain_count_reg - 1'b1;
        if (drain_count_reg <= DRAIN_W'(1)) begin
          state_next = HALTED;
        end
      end
      HALTED: begin
        if (bus.i_cmd_clear) begin
          count_clear = 1'b1;
          state_next  = IDLE;
        end
      end
      default: begin
        // Illegal encodings recover to IDLE on the next edge
        state_next = IDLE;
      end
    endcase
  end

  // Enabled-cycle counter: clear first, otherwise saturating increment
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cycle_count_reg <= '0;
    end else if (count_clear) begin
      cycle_count_reg <= '0;
    end else if (stages_active && (cycle_count_reg != COUNT_MAX)) begin
      cycle_count_reg <= cycle_count_reg + 1'b1;
    end
  end

  // Step-completion pulse, one cycle after any STEP cycle
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      step_done_reg <= 1'b0;
    end else begin
      step_done_reg <= (state_reg == STEP);
    end
  end

  // Moore output decode
  always_comb begin
    bus.o_enable_pipeline = stages_active;
    bus.o_enable_etapa    = stages_active;
    bus.o_enable_fetch    = (state_reg == RUN) || (state_reg == STEP);
    bus.o_halted          = (state_reg == HALTED);
    bus.o_step_done       = step_done_reg;
    bus.o_cycle_count     = cycle_count_reg;
    bus.o_state           = state_reg;
  end

endmodule
